// File: rtl/life_ctrl_pkg.sv
// life_ctrl_pkg
// Shared definitions for the Game-of-Life array controller: host opcodes,
// the controller FSM state enumeration, the step-pulser phase enumeration
// and a decode helper telling which controller states accept a host byte.
package life_ctrl_pkg;

  // Host opcodes recognised in IDLE.
  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_STEP = 8'h02;
  localparam logic [7:0] OP_READ = 8'h03;

  // Controller FSM states.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LD0   = 4'd1,
    ST_LD1   = 4'd2,
    ST_WRITE = 4'd3,
    ST_SCNT  = 4'd4,
    ST_SHI   = 4'd5,
    ST_SLO   = 4'd6,
    ST_RD0   = 4'd7,
    ST_RD1   = 4'd8
  } ctrl_state_e;

  // Step pulser phases.
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_HI   = 2'd1,
    PH_LO   = 2'd2
  } pulse_phase_e;

  // True for the states in which the controller takes a host byte.
  function automatic logic accepts_input(input ctrl_state_e s);
    logic r;
    case (s)
      ST_IDLE, ST_LD0, ST_LD1, ST_SCNT: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/life_step_pulser.sv
// life_step_pulser
// Generates one step pulse per start request: step is held high for
// STEP_HIGH cycles, then low for STEP_GAP cycles. A start seen on the final
// gap cycle chains straight into the next pulse with no extra idle cycle.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   srst       synchronous clear (held while the controller is in reset)
//   start      begin a pulse (sampled in idle or on the final gap cycle)
//   step       step output to the array
//   high_last  1 on the last high cycle of a pulse
//   done       1 on the last gap cycle of a pulse
module life_step_pulser
  import life_ctrl_pkg::*;
#(
  parameter int unsigned STEP_HIGH = 2,
  parameter int unsigned STEP_GAP  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic srst,
  input  logic start,
  output logic step,
  output logic high_last,
  output logic done
);

  // Counters are loaded with length-1 and run down to zero.
  localparam logic [15:0] HIGH_LOAD = 16'(STEP_HIGH - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(STEP_GAP - 1);

  pulse_phase_e phase_q, phase_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         cnt_zero_s;

  assign cnt_zero_s = (cnt_q == 16'd0);

  // Phase / down-counter next-state logic.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (srst) begin
      phase_d = PH_IDLE;
      cnt_d   = 16'd0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (start) begin
            phase_d = PH_HI;
            cnt_d   = HIGH_LOAD;
          end else begin
            phase_d = PH_IDLE;
          end
        end
        PH_HI: begin
          if (cnt_zero_s) begin
            phase_d = PH_LO;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        PH_LO: begin
          if (cnt_zero_s) begin
            if (start) begin
              phase_d = PH_HI;
              cnt_d   = HIGH_LOAD;
            end else begin
              phase_d = PH_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          phase_d = PH_IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  // Phase and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= 16'd0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign step      = (phase_q == PH_HI);
  assign high_last = (phase_q == PH_HI) && cnt_zero_s;
  assign done      = (phase_q == PH_LO) && cnt_zero_s;

endmodule

// File: rtl/life_array_ctrl.sv
// life_array_ctrl
// Byte-command controller for a 16-cell Game-of-Life array.
//   0x01 lo hi : LOAD  - drive val={hi,lo}, one write_enb cycle, gen_count=0
//   0x02 N     : STEP  - N step pulses (N=0 does nothing), gen_count += N
//   0x03       : READ  - snapshot alive, return alive[7:0] then alive[15:8]
//   other      : consumed and ignored
// Optional build macro LIFE_CTRL_AUTOREAD_EN: a STEP with N>0 ends with an
// automatic readback of alive (snapshotted on the last gap cycle).
// Ports:
//   clk, reset (async active-low, release synchronised to clk)
//   in_data/in_valid/in_ready     host command byte stream
//   val, write_enb, step          drive to the array
//   alive                         array cell state
//   out_data/out_valid/out_ready  readback byte stream
//   busy                          FSM not in IDLE
//   gen_count                     generations stepped since the last LOAD
module life_array_ctrl
  import life_ctrl_pkg::*;
#(
  parameter int unsigned STEP_GAP  = 4,
  parameter int unsigned STEP_HIGH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] val,
  output logic        write_enb,
  output logic        step,
  input  logic [15:0] alive,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] gen_count
);

  ctrl_state_e state_q, state_d;
  logic [15:0] val_q, val_d;
  logic [7:0]  ld_lo_q, ld_lo_d;
  logic [7:0]  count_q, count_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] gen_count_q, gen_count_d;
  logic        rst_sync_q, rst_sync_d;

  logic        run_s;
  logic        in_ready_s;
  logic        in_fire_s;
  logic        start_s;
  logic        step_s;
  logic        high_last_s;
  logic        pulse_done_s;
  logic [7:0]  out_data_s;

  assign rst_sync_d = 1'b1;

  // Reset release synchroniser: the FSM stays cleared until the first
  // rising edge after reset deasserts, so bytes are taken from the second.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign run_s      = rst_sync_q;
  assign in_ready_s = accepts_input(state_q);
  assign in_fire_s  = in_valid & in_ready_s & run_s;

  life_step_pulser #(
    .STEP_HIGH (STEP_HIGH),
    .STEP_GAP  (STEP_GAP)
  ) u_pulser (
    .clk       (clk),
    .reset     (reset),
    .srst      (~run_s),
    .start     (start_s),
    .step      (step_s),
    .high_last (high_last_s),
    .done      (pulse_done_s)
  );

  // Controller next-state logic.
  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    ld_lo_d     = ld_lo_q;
    count_d     = count_q;
    snap_d      = snap_q;
    gen_count_d = gen_count_q;
    start_s     = 1'b0;
    if (!run_s) begin
      state_d     = ST_IDLE;
      val_d       = 16'h0000;
      ld_lo_d     = 8'h00;
      count_d     = 8'h00;
      snap_d      = 16'h0000;
      gen_count_d = 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_fire_s) begin
            case (in_data)
              OP_LOAD: state_d = ST_LD0;
              OP_STEP: state_d = ST_SCNT;
              OP_READ: begin
                snap_d  = alive;
                state_d = ST_RD0;
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        // Low byte is staged so val only changes once the LOAD is complete.
        ST_LD0: begin
          if (in_fire_s) begin
            ld_lo_d = in_data;
            state_d = ST_LD1;
          end else begin
            state_d = ST_LD0;
          end
        end
        ST_LD1: begin
          if (in_fire_s) begin
            val_d   = {in_data, ld_lo_q};
            state_d = ST_WRITE;
          end else begin
            state_d = ST_LD1;
          end
        end
        ST_WRITE: begin
          gen_count_d = 16'h0000;
          state_d     = ST_IDLE;
        end
        ST_SCNT: begin
          if (in_fire_s) begin
            count_d = in_data;
            if (in_data == 8'h00) begin
              state_d = ST_IDLE;
            end else begin
              start_s     = 1'b1;
              gen_count_d = gen_count_q + 16'd1;
              state_d     = ST_SHI;
            end
          end else begin
            state_d = ST_SCNT;
          end
        end
        ST_SHI: begin
          if (high_last_s) begin
            state_d = ST_SLO;
          end else begin
            state_d = ST_SHI;
          end
        end
        // On the last gap cycle either chain the next pulse or finish.
        ST_SLO: begin
          if (pulse_done_s) begin
            count_d = count_q - 8'd1;
            if (count_q != 8'd1) begin
              start_s     = 1'b1;
              gen_count_d = gen_count_q + 16'd1;
              state_d     = ST_SHI;
            end else begin
`ifdef LIFE_CTRL_AUTOREAD_EN
              snap_d  = alive;
              state_d = ST_RD0;
`else
              state_d = ST_IDLE;
`endif
            end
          end else begin
            state_d = ST_SLO;
          end
        end
        ST_RD0: begin
          if (out_ready) begin
            state_d = ST_RD1;
          end else begin
            state_d = ST_RD0;
          end
        end
        ST_RD1: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RD1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Controller state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      val_q       <= 16'h0000;
      ld_lo_q     <= 8'h00;
      count_q     <= 8'h00;
      snap_q      <= 16'h0000;
      gen_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      ld_lo_q     <= ld_lo_d;
      count_q     <= count_d;
      snap_q      <= snap_d;
      gen_count_q <= gen_count_d;
    end
  end

  // Readback byte selection from the held snapshot.
  always_comb begin
    out_data_s = 8'h00;
    case (state_q)
      ST_RD0:  out_data_s = snap_q[7:0];
      ST_RD1:  out_data_s = snap_q[15:8];
      default: out_data_s = 8'h00;
    endcase
  end

  assign in_ready  = in_ready_s;
  assign val       = val_q;
  assign write_enb = (state_q == ST_WRITE);
  assign step      = step_s;
  assign out_data  = out_data_s;
  assign out_valid = (state_q == ST_RD0) || (state_q == ST_RD1);
  assign busy      = (state_q != ST_IDLE);
  assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_array_ctrl.sv
// Self-checking bench for life_array_ctrl. A behavioural model (expected
// val, generation count, pulse trains and readback bytes) lives here.
module tb_life_array_ctrl;

  localparam int H = 2;
  localparam int G = 4;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] val;
  logic        write_enb;
  logic        step;
  logic [15:0] alive;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] gen_count;

  int n_pass  = 0;
  int n_total = 0;

  // model state
  logic [15:0] model_val = 16'h0000;
  int          model_gen = 0;

  // write strobe monitor
  int          wr_events = 0;
  logic [15:0] wr_last_val = 16'h0000;

  life_array_ctrl #(.STEP_GAP(G), .STEP_HIGH(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .val       (val),
    .write_enb (write_enb),
    .step      (step),
    .alive     (alive),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .gen_count (gen_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enb === 1'b1) begin
      wr_events   = wr_events + 1;
      wr_last_val = val;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_total++;
      $display("FAIL send_byte_timeout byte=%02h in_ready=%b required 1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s_idle busy=%b required 0", name, busy);
    else n_pass++;
  endtask

  // Readback of a 16-bit snapshot with a given number of stall cycles.
  // alive is scrambled during the stall to show the snapshot is held.
  task automatic expect_readback(input logic [15:0] exp, input int stall);
    int bad;
    bad = 0;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== exp[7:0]) bad++;
      alive = 16'($urandom);
    end
    n_total++;
    if (bad != 0) $display("FAIL rd_stall_hold bad_cycles=%0d required 0 (exp %02h)", bad, exp[7:0]);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_data} !== {1'b1, exp[7:0]})
      $display("FAIL rd_byte0 valid=%b data=%02h required 1/%02h", out_valid, out_data, exp[7:0]);
    else n_pass++;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_total++;
    if ({out_valid, out_data} !== {1'b1, exp[15:8]})
      $display("FAIL rd_byte1 valid=%b data=%02h required 1/%02h", out_valid, out_data, exp[15:8]);
    else n_pass++;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rd_end valid=%b busy=%b required 0/0", out_valid, busy);
    else n_pass++;
  endtask

  // STEP command with N pulses, compared against an ideal pulse train.
  task automatic do_step(input int n);
    bit exp_q[$];
    bit got_q[$];
    int bad;
    logic [15:0] alive_hold;
    alive_hold = alive;
    send_byte(8'h02);
    send_byte(8'(n));
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < H; i++) exp_q.push_back(1'b1);
      for (int i = 0; i < G; i++) exp_q.push_back(1'b0);
    end
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || out_valid === 1'b1) break;
      got_q.push_back(step);
    end
    model_gen = (model_gen + n) % 65536;
    n_total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL step_len n=%0d busy_cycles=%0d required %0d", n, got_q.size(), exp_q.size());
    else n_pass++;
    bad = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) bad++;
    n_total++;
    if (bad != 0) $display("FAIL step_wave n=%0d wrong_cycles=%0d required 0", n, bad);
    else n_pass++;
    n_total++;
    if (gen_count !== 16'(model_gen))
      $display("FAIL step_gen gen_count=%04h required %04h", gen_count, 16'(model_gen));
    else n_pass++;
`ifdef LIFE_CTRL_AUTOREAD_EN
    if (n != 0) expect_readback(alive_hold, int'($urandom_range(0, 3)));
    else begin
      n_total++;
      if (busy !== 1'b0 || out_valid !== 1'b0)
        $display("FAIL step_end busy=%b out_valid=%b required 0/0", busy, out_valid);
      else n_pass++;
    end
`else
    n_total++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL step_end busy=%b out_valid=%b required 0/0 (alive %04h)", busy, out_valid, alive_hold);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    alive     = 16'h0000;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({val, write_enb, step, out_valid, out_data, gen_count, busy, in_ready} !==
        {16'h0000, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1})
      $display("FAIL reset_state val=%04h we=%b step=%b ov=%b od=%02h gen=%04h busy=%b ir=%b required 0/0/0/0/00/0000/0/1",
               val, write_enb, step, out_valid, out_data, gen_count, busy, in_ready);
    else n_pass++;
    reset = 1'b1;
    model_val = 16'h0000;
    model_gen = 0;
  endtask

  // First LOAD issued so its opcode lands on the second edge after release.
  task automatic test_load_fixed();
    int w0;
    w0 = wr_events;
    send_byte(8'h01);
    send_byte(8'h34);
    send_byte(8'h12);
    wait_idle("load_fixed");
    model_val = 16'h1234;
    model_gen = 0;
    n_total++;
    if (wr_events - w0 != 1) $display("FAIL load_we_count got=%0d required 1", wr_events - w0);
    else n_pass++;
    n_total++;
    if (wr_last_val !== model_val) $display("FAIL load_val_at_we got=%04h required %04h", wr_last_val, model_val);
    else n_pass++;
    n_total++;
    if (gen_count !== 16'h0000) $display("FAIL load_gen got=%04h required 0000", gen_count);
    else n_pass++;
  endtask

  task automatic test_step_default();
    alive = 16'h3C5A;
    do_step(3);
    n_total++;
    if (val !== model_val) $display("FAIL step_val_hold got=%04h required %04h", val, model_val);
    else n_pass++;
  endtask

  task automatic test_read_stall();
    alive = 16'hA5C3;
    send_byte(8'h03);
    expect_readback(16'hA5C3, 5);
  endtask

  task automatic test_zero_and_junk();
    int highs;
    int busies;
    send_byte(8'h02);
    send_byte(8'h00);
    highs  = 0;
    busies = 0;
    repeat (8) begin
      @(negedge clk);
      if (step === 1'b1) highs++;
      if (busy === 1'b1) busies++;
    end
    n_total++;
    if (highs != 0 || busies != 0) $display("FAIL step0 step_cycles=%0d busy_cycles=%0d required 0/0", highs, busies);
    else n_pass++;
    send_byte(8'h7F);
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, step, out_valid} !== 3'b000) $display("FAIL junk_ignored busy/step/ov=%b required 000", {busy, step, out_valid});
    else n_pass++;
    n_total++;
    if (gen_count !== 16'(model_gen) || val !== model_val)
      $display("FAIL junk_state gen=%04h val=%04h required %04h/%04h", gen_count, val, 16'(model_gen), model_val);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    int w0;
    int we_seen;
    logic [15:0] r;
    w0 = wr_events;
    send_byte(8'h01);
    send_byte(8'h34);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if ({val, write_enb, busy, in_ready, gen_count} !== {16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000})
      $display("FAIL midreset_state val=%04h we=%b busy=%b ir=%b gen=%04h required 0000/0/0/1/0000",
               val, write_enb, busy, in_ready, gen_count);
    else n_pass++;
    we_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (write_enb === 1'b1) we_seen++;
    end
    reset = 1'b1;
    model_val = 16'h0000;
    model_gen = 0;
    repeat (4) @(negedge clk);
    n_total++;
    if (we_seen != 0 || wr_events != w0 || val !== 16'h0000)
      $display("FAIL midreset_no_load we_cycles=%0d events=%0d val=%04h required 0/0/0000", we_seen, wr_events - w0, val);
    else n_pass++;
    r = 16'($urandom);
    send_byte(8'h01);
    send_byte(r[7:0]);
    send_byte(r[15:8]);
    wait_idle("midreset_reload");
    model_val = r;
    n_total++;
    if (val !== r || wr_events - w0 != 1)
      $display("FAIL midreset_reload val=%04h events=%0d required %04h/1", val, wr_events - w0, r);
    else n_pass++;
  endtask

  // Commands issued while the controller is not ready stay pending.
  task automatic test_back_to_back();
    int w0;
    logic [15:0] a;
    logic [15:0] b;
    w0 = wr_events;
    a = 16'($urandom);
    b = 16'($urandom);
    send_byte(8'h01); send_byte(a[7:0]); send_byte(a[15:8]);
    send_byte(8'h01); send_byte(b[7:0]); send_byte(b[15:8]);
    alive = 16'($urandom);
    a = alive;
    send_byte(8'h03);
    model_val = b;
    model_gen = 0;
    n_total++;
    if (wr_events - w0 != 2 || val !== b || wr_last_val !== b)
      $display("FAIL b2b_loads events=%0d val=%04h required 2/%04h", wr_events - w0, val, b);
    else n_pass++;
    expect_readback(a, 1);
  endtask

  task automatic test_random();
    int sel;
    int n;
    logic [15:0] r;
    logic [7:0]  junk;
    for (int it = 0; it < 12; it++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: begin
          r = 16'($urandom);
          send_byte(8'h01); send_byte(r[7:0]); send_byte(r[15:8]);
          wait_idle("rand_load");
          model_val = r;
          model_gen = 0;
          n_total++;
          if (val !== model_val || gen_count !== 16'h0000)
            $display("FAIL rand_load val=%04h gen=%04h required %04h/0000", val, gen_count, model_val);
          else n_pass++;
        end
        1: begin
          n = int'($urandom_range(0, 3));
          alive = 16'($urandom);
          do_step(n);
        end
        2: begin
          alive = 16'($urandom);
          r = alive;
          send_byte(8'h03);
          expect_readback(r, int'($urandom_range(0, 4)));
        end
        default: begin
          junk = 8'($urandom_range(4, 255));
          send_byte(junk);
          repeat (2) @(negedge clk);
          n_total++;
          if (busy !== 1'b0 || gen_count !== 16'(model_gen) || val !== model_val)
            $display("FAIL rand_junk byte=%02h busy=%b gen=%04h val=%04h required 0/%04h/%04h",
                     junk, busy, gen_count, val, 16'(model_gen), model_val);
          else n_pass++;
        end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_load_fixed();
    test_step_default();
    test_read_stall();
    test_zero_and_junk();
    test_reset_mid_load();
    test_back_to_back();
    alive = 16'h0F96;
    do_step(1);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/life_array_ctrl.md
LIFE_ARRAY_CTRL -- requirements
Module: life_array_ctrl

Interface
REQ-001 SHALL have parameter STEP_GAP, default 4: cycles step is held low between pulses; legal minimum 2.
REQ-002 SHALL have parameter STEP_HIGH, default 2: cycles step is held high per pulse; legal minimum 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low; asserted when 0.
REQ-005 SHALL have port in_data, input, 8: host command/payload byte.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: controller accepts a byte.
REQ-008 SHALL have port val, output, 16: pattern driven to the array.
REQ-009 SHALL have port write_enb, output, 1: array load strobe.
REQ-010 SHALL have port step, output, 1: array step request.
REQ-011 SHALL have port alive, input, 16: array cell state, bit i = cell i.
REQ-012 SHALL have port out_data, output, 8: readback byte.
REQ-013 SHALL have port out_valid, output, 1: out_data valid.
REQ-014 SHALL have port out_ready, input, 1: host accepts out_data.
REQ-015 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-016 SHALL have port gen_count, output, 16: generations stepped since the last LOAD.

Function
REQ-017 A byte transfers only on a rising edge where in_valid and in_ready are both 1; an out byte transfers only where out_valid and out_ready are both 1.
REQ-018 FSM states SHALL be IDLE, LD0, LD1, WRITE, SCNT, SHI, SLO, RD0, RD1; in_ready SHALL be 1 only in IDLE, LD0, LD1 and SCNT.
REQ-019 In IDLE, opcode 0x01 -> LD0, 0x02 -> SCNT, 0x03 -> RD0 with alive snapshotted into a 16-bit holding register on the same edge; any other byte SHALL be consumed and ignored.
REQ-020 LD0 SHALL capture val[7:0]; LD1 SHALL capture val[15:8] -> WRITE.
REQ-021 WRITE SHALL drive write_enb=1 for exactly one cycle, clear gen_count to 0, and return to IDLE; val SHALL hold its value until the next LOAD.
REQ-022 SCNT SHALL capture an 8-bit count N; N=0 -> IDLE with no pulse; else -> SHI.
REQ-023 SHI SHALL drive step=1 for STEP_HIGH cycles, then go to SLO; SLO SHALL drive step=0 for STEP_GAP cycles, then decrement N and go to SHI if N is nonzero, else IDLE.
REQ-024 gen_count SHALL increment once per SHI entry and wrap from 0xFFFF to 0x0000.
REQ-025 RD0 SHALL present snapshot[7:0] with out_valid=1, held stable until accepted, then go to RD1; RD1 SHALL present snapshot[15:8], then go to IDLE.
REQ-026 out_valid SHALL be 0 in all states other than RD0 and RD1; out_data SHALL not change while out_valid=1 and out_ready=0.
REQ-027 in_valid asserted while in_ready=0 SHALL be left pending and not dropped.

Reset
REQ-028 Reset assertion SHALL immediately force IDLE, val=0, write_enb=0, step=0, out_valid=0, out_data=0, gen_count=0, busy=0 and in_ready=1, including mid-sequence; no partial LOAD SHALL be applied.
REQ-029 Deassertion SHALL be synchronized to clk; the first byte can be accepted on the second rising edge after deassertion.

Configuration
REQ-030 With LIFE_CTRL_AUTOREAD_EN defined, the last SLO of a STEP with N>0 SHALL snapshot alive and go to RD0 instead of IDLE; without it, it SHALL return to IDLE and produce no output.

Structure
REQ-031 Package life_ctrl_pkg SHALL hold the opcode constants (0x01, 0x02, 0x03) and the FSM state enumeration.
REQ-032 The step timing (SHI/SLO counters) SHALL be a sub-module life_step_pulser with a start input, a done output and step as its output.

Verification
REQ-033 Bytes 0x01, 0x34, 0x12 -> exactly one write_enb cycle with val=0x1234, gen_count=0.
REQ-034 Bytes 0x02, 0x03 (defaults) -> three step pulses, each 2 cycles high with 4 low between; gen_count=3; busy low after the final SLO.
REQ-035 alive=0xA5C3, byte 0x03, out_ready held 0 for 5 cycles -> out_data stays 0xC3 with out_valid=1, then 0xA5 follows, then IDLE.
REQ-036 Bytes 0x02, 0x00 -> no step pulse; byte 0x7F -> ignored; gen_count unchanged.
REQ-037 Reset asserted after the 0x34 of a LOAD -> write_enb never pulses and val=0; a fresh LOAD then succeeds.
REQ-038 With LIFE_CTRL_AUTOREAD_EN, bytes 0x02, 0x01 -> one step pulse followed by two readback bytes equal to the alive snapshot.
